// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: derives per-register stall/bubble vectors from cache misses,
// load-use hazards, taken branches and a two-phase LDI/STI access sequencer.
module pipeline_hazard_ctrl #(
    parameter int NUM_REGS   = 5,
    parameter int REG_ADDR_W = 3,
    parameter int BR_LEVEL   = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_if_req,
    input  logic                  i_if_resp,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic                  i_mem_resp,
    input  logic                  i_ind_start,
    input  logic [REG_ADDR_W-1:0] i_id_src1,
    input  logic [REG_ADDR_W-1:0] i_id_src2,
    input  logic                  i_id_src1_v,
    input  logic                  i_id_src2_v,
    input  logic [REG_ADDR_W-1:0] i_ex_dest,
    input  logic                  i_ex_is_load,
    input  logic                  i_br_taken,
    output logic [NUM_REGS-1:0]   o_stall,
    output logic [NUM_REGS-1:0]   o_bubble,
    output logic                  o_pc_redirect,
    output logic                  o_ind_phase,
    output logic                  o_ind_busy,
    output logic [CNT_W-1:0]      o_stall_cycles
);

    localparam int LW = $clog2(NUM_REGS + 1);

    typedef enum logic [1:0] {
        IND_IDLE,
        IND_ADDR,
        IND_DATA
    } ind_state_t;

    ind_state_t       r_state;
    ind_state_t       w_state_nxt;
    logic             w_ind_stall;
    logic             w_imiss;
    logic             w_dmiss;
    logic             w_load_use;
    logic             w_full;
    logic             w_flush;
    logic [LW-1:0]    w_level;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IND_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The start cycle already stalls, so the LDI/STI never advances past MEM.
    always_comb begin
        w_state_nxt = r_state;
        w_ind_stall = 1'b0;
        case (r_state)
            IND_IDLE: begin
                if (i_ind_start) begin
                    w_state_nxt = IND_ADDR;
                    w_ind_stall = 1'b1;
                end
            end
            IND_ADDR: begin
                w_ind_stall = 1'b1;
                if (i_mem_resp) begin
                    w_state_nxt = IND_DATA;
                end
            end
            IND_DATA: begin
                if (i_mem_resp) begin
                    w_state_nxt = IND_IDLE;
                end else begin
                    w_ind_stall = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IND_IDLE;
            end
        endcase
    end

    assign w_imiss    = i_if_req & ~i_if_resp;
    assign w_dmiss    = (i_mem_read | i_mem_write) & ~i_mem_resp;
    assign w_load_use = i_ex_is_load &
                        ((i_id_src1_v & (i_id_src1 == i_ex_dest)) |
                         (i_id_src2_v & (i_id_src2 == i_ex_dest)));
    assign w_full     = w_dmiss | w_ind_stall;
    assign w_flush    = i_br_taken & ~w_full;

    // Sources are ordered by increasing level, so the last match is the max.
    always_comb begin
        w_level = '0;
        if (w_imiss) begin
            w_level = LW'(1);
        end
        if (w_load_use) begin
            w_level = LW'(2);
        end
        if (w_full) begin
            w_level = LW'(NUM_REGS);
        end
    end

    always_comb begin
        o_stall  = '0;
        o_bubble = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_flush && (i <= BR_LEVEL)) begin
                o_stall[i]  = 1'b0;
                o_bubble[i] = (i >= 1);
            end else begin
                o_stall[i]  = (i < int'(w_level));
                o_bubble[i] = (i != 0) && (i == int'(w_level));
            end
        end
        if (i_rst) begin
            o_stall  = '0;
            o_bubble = {{(NUM_REGS-1){1'b1}}, 1'b0};
        end
    end

    assign o_pc_redirect = w_flush & ~i_rst;
    assign o_ind_phase   = (r_state == IND_DATA) & ~i_rst;
    assign o_ind_busy    = (r_state != IND_IDLE) & ~i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if ((|o_stall) && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_stall_cycles = r_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random
// traffic compared each cycle against a level-based behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int NR = 5;
    localparam int BR = 3;

    logic       clk;
    logic       rst;
    logic       if_req, if_resp, mem_read, mem_write, mem_resp, ind_start;
    logic [2:0] id_src1, id_src2, ex_dest;
    logic       id_src1_v, id_src2_v, ex_is_load, br_taken;

    logic [NR-1:0] d_stall, d_bubble, s_stall, s_bubble;
    logic          d_redir, d_phase, d_busy, s_redir, s_phase, s_busy;
    logic [15:0]   d_cnt;
    logic [3:0]    s_cnt;

    int n_total = 0;
    int n_bad   = 0;

    // model state
    bit        m_busy, m_got;
    int        m_cnt16, m_cnt4;
    logic [NR-1:0] e_stall, e_bubble;
    logic      e_redir, e_phase, e_busy;

    pipeline_hazard_ctrl u_dut (
        .i_clk(clk), .i_rst(rst), .i_if_req(if_req), .i_if_resp(if_resp),
        .i_mem_read(mem_read), .i_mem_write(mem_write), .i_mem_resp(mem_resp),
        .i_ind_start(ind_start), .i_id_src1(id_src1), .i_id_src2(id_src2),
        .i_id_src1_v(id_src1_v), .i_id_src2_v(id_src2_v), .i_ex_dest(ex_dest),
        .i_ex_is_load(ex_is_load), .i_br_taken(br_taken),
        .o_stall(d_stall), .o_bubble(d_bubble), .o_pc_redirect(d_redir),
        .o_ind_phase(d_phase), .o_ind_busy(d_busy), .o_stall_cycles(d_cnt)
    );

    pipeline_hazard_ctrl #(.CNT_W(4)) u_sat (
        .i_clk(clk), .i_rst(rst), .i_if_req(if_req), .i_if_resp(if_resp),
        .i_mem_read(mem_read), .i_mem_write(mem_write), .i_mem_resp(mem_resp),
        .i_ind_start(ind_start), .i_id_src1(id_src1), .i_id_src2(id_src2),
        .i_id_src1_v(id_src1_v), .i_id_src2_v(id_src2_v), .i_ex_dest(ex_dest),
        .i_ex_is_load(ex_is_load), .i_br_taken(br_taken),
        .o_stall(s_stall), .o_bubble(s_bubble), .o_pc_redirect(s_redir),
        .o_ind_phase(s_phase), .o_ind_busy(s_busy), .o_stall_cycles(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: stall level as the max of active sources, flush on top.
    task automatic model_eval();
        int lvl;
        bit ind_hold, flush, in_br;
        lvl = 0;
        if (if_req && !if_resp) lvl = 1;
        if (ex_is_load && ((id_src1_v && id_src1 == ex_dest) || (id_src2_v && id_src2 == ex_dest)))
            lvl = (lvl > 2) ? lvl : 2;
        ind_hold = (!m_busy && ind_start) || (m_busy && !m_got) || (m_busy && m_got && !mem_resp);
        if (((mem_read || mem_write) && !mem_resp) || ind_hold) lvl = NR;
        flush = br_taken && (lvl < NR);
        for (int i = 0; i < NR; i++) begin
            in_br = flush && (i <= BR);
            e_stall[i]  = !in_br && (i < lvl);
            e_bubble[i] = in_br ? (i >= 1) : (i > 0 && i == lvl);
        end
        e_redir = flush;
        e_phase = m_busy && m_got;
        e_busy  = m_busy;
        if (rst) begin
            e_stall  = '0;
            e_bubble = 5'b11110;
            e_redir  = 1'b0;
            e_phase  = 1'b0;
            e_busy   = 1'b0;
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_cnt16 = 0;
            m_cnt4  = 0;
            m_busy  = 0;
            m_got   = 0;
        end else begin
            if (|e_stall) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (!m_busy) begin
                if (ind_start) begin
                    m_busy = 1;
                    m_got  = 0;
                end
            end else if (!m_got) begin
                if (mem_resp) m_got = 1;
            end else if (mem_resp) begin
                m_busy = 0;
                m_got  = 0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_eval();
        chk("stall", d_stall, e_stall);
        chk("bubble", d_bubble, e_bubble);
        chk("redirect", d_redir, e_redir);
        chk("ind_phase", d_phase, e_phase);
        chk("ind_busy", d_busy, e_busy);
        chk("cnt16", d_cnt, m_cnt16);
        chk("cnt4", s_cnt, m_cnt4);
        chk("sat_stall", s_stall, e_stall);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 0; if_resp = 0; mem_read = 0; mem_write = 0; mem_resp = 0;
        ind_start = 0; id_src1 = 0; id_src2 = 0; id_src1_v = 0; id_src2_v = 0;
        ex_dest = 0; ex_is_load = 0; br_taken = 0;
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        m_busy = 0; m_got = 0; m_cnt16 = 0; m_cnt4 = 0;
        #1;
        chk("rst_bubble", d_bubble, 5'b11110);
        chk("rst_stall", d_stall, 5'b00000);
        step();
        step();
        chk("rst_cnt", d_cnt, 0);
        rst = 0;
        step();

        // I-cache miss for three cycles
        if_req = 1; if_resp = 0;
        #1;
        chk("imiss_stall", d_stall, 5'b00001);
        chk("imiss_bubble", d_bubble, 5'b00010);
        repeat (3) step();
        if_resp = 1;
        #1;
        chk("imiss_done", d_stall, 5'b00000);
        step();
        chk("imiss_cnt", d_cnt, 3);
        clear_inputs();

        // load-use hazard, then same with the source unused
        ex_is_load = 1; ex_dest = 3; id_src2 = 3; id_src2_v = 1;
        #1;
        chk("lu_stall", d_stall, 5'b00011);
        chk("lu_bubble", d_bubble, 5'b00100);
        step();
        id_src2_v = 0;
        #1;
        chk("lu_unused", d_stall, 5'b00000);
        step();
        clear_inputs();

        // D-miss overlapping I-miss, then drop the D-miss
        mem_read = 1; mem_resp = 0; if_req = 1; if_resp = 0;
        #1;
        chk("dmiss_stall", d_stall, 5'b11111);
        chk("dmiss_bubble", d_bubble, 5'b00000);
        step();
        mem_read = 0;
        #1;
        chk("dmiss_drop", d_stall, 5'b00001);
        step();
        clear_inputs();

        // LDI sequence, memory responses on cycles 3 and 6
        for (int c = 0; c < 8; c++) begin
            ind_start = (c == 0);
            mem_resp  = (c == 3 || c == 6);
            #1;
            chk("ldi_stall", d_stall, (c <= 5) ? 5'b11111 : 5'b00000);
            chk("ldi_phase", d_phase, (c >= 4 && c <= 6));
            chk("ldi_busy", d_busy, (c >= 1 && c <= 6));
            step();
        end
        // repeat with reset in the middle of the data phase
        for (int c = 0; c < 7; c++) begin
            ind_start = (c == 0);
            mem_resp  = (c == 3 || c == 6);
            rst       = (c == 4);
            #1;
            if (c == 5) begin
                chk("ldi_rst_busy", d_busy, 1'b0);
                chk("ldi_rst_stall", d_stall, 5'b00000);
            end
            step();
        end
        rst = 0;
        clear_inputs();

        // branch versus load-use, then branch deferred by D-miss
        ex_is_load = 1; ex_dest = 3; id_src2 = 3; id_src2_v = 1; br_taken = 1;
        #1;
        chk("br_redir", d_redir, 1'b1);
        chk("br_bubble", d_bubble, 5'b01110);
        chk("br_stall", d_stall, 5'b00000);
        step();
        ex_is_load = 0; mem_read = 1; mem_resp = 0;
        #1;
        chk("br_defer", d_redir, 1'b0);
        chk("br_defer_stall", d_stall, 5'b11111);
        step();
        mem_resp = 1;
        #1;
        chk("br_release", d_redir, 1'b1);
        step();
        clear_inputs();

        // counter saturation on the narrow instance
        rst = 1;
        step();
        rst = 0;
        if_req = 1;
        repeat (20) step();
        chk("sat_cnt", s_cnt, 15);
        chk("wide_cnt", d_cnt, 20);
        repeat (2) step();
        chk("sat_held", s_cnt, 15);
        clear_inputs();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 39) == 0);
            if_req     = $urandom_range(0, 1);
            if_resp    = $urandom_range(0, 1);
            mem_read   = ($urandom_range(0, 3) == 0);
            mem_write  = ($urandom_range(0, 5) == 0);
            mem_resp   = $urandom_range(0, 1);
            ind_start  = ($urandom_range(0, 7) == 0);
            id_src1    = 3'($urandom_range(0, 7));
            id_src2    = 3'($urandom_range(0, 7));
            ex_dest    = 3'($urandom_range(0, 7));
            id_src1_v  = $urandom_range(0, 1);
            id_src2_v  = $urandom_range(0, 1);
            ex_is_load = $urandom_range(0, 1);
            br_taken   = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
